// File: rtl/ctrl_exec_wb.sv
// rtl/ctrl_exec_wb.sv - execute/write-back end of the control bus: PC, register write port, redirects, multiplier sequencing
module ctrl_exec_wb #(
    parameter int PC_W        = 12,
    parameter int MUL_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [15:0]     ctrl_in,
    input  logic [11:0]     regs_in,
    input  logic [15:0]     alu_result,
    input  logic            alu_zero,
    input  logic [15:0]     mul_result,
    input  logic            mul_done,
    output logic [PC_W-1:0] pc,
    output logic            reg_we,
    output logic [3:0]      reg_waddr,
    output logic [15:0]     reg_wdata,
    output logic            mul_start,
    output logic            stall,
    output logic            flush,
    output logic            err
);

    localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_MUL_WB} state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_reg_we;
    logic [3:0]       r_reg_waddr;
    logic [15:0]      r_reg_wdata;
    logic             r_mul_start;
    logic             r_stall;
    logic             r_flush;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_mul_dest;
    logic             r_mul_we;
    logic [15:0]      r_prod;

    logic             w_esc_cond;
    logic             w_esc_cp;
    logic [1:0]       w_fonte;
    logic             w_esc_reg;
    logic             w_mul;
    logic [PC_W-1:0]  w_pc_inc;
    logic [PC_W-1:0]  w_pc_br;
    logic [PC_W-1:0]  w_pc_jmp;
    logic             w_unused;

    assign w_esc_cond = ctrl_in[0];
    assign w_esc_cp   = ctrl_in[1];
    assign w_fonte    = ctrl_in[7:6];
    assign w_esc_reg  = ctrl_in[8];
    assign w_mul      = ctrl_in[10];
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_pc_br    = r_pc + PC_W'($signed(regs_in[11:8]));
    assign w_pc_jmp   = PC_W'(regs_in);
    assign w_unused   = ^{ctrl_in[15:11], ctrl_in[9], ctrl_in[5:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_reg_we    <= 1'b0;
            r_reg_waddr <= '0;
            r_reg_wdata <= '0;
            r_mul_start <= 1'b0;
            r_stall     <= 1'b0;
            r_flush     <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_mul_dest  <= '0;
            r_mul_we    <= 1'b0;
            r_prod      <= '0;
        end else begin
            r_reg_we    <= 1'b0;
            r_flush     <= 1'b0;
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (w_mul) begin
                            // Destination is captured here so the write-back does not depend on the producer holding regs_in.
                            r_mul_start <= 1'b1;
                            r_stall     <= 1'b1;
                            r_cnt       <= '0;
                            r_mul_dest  <= regs_in[11:8];
                            r_mul_we    <= w_esc_reg;
                            r_state     <= S_MUL_WAIT;
                        end else begin
                            r_reg_we    <= w_esc_reg && (w_fonte != 2'b01);
                            r_reg_waddr <= regs_in[11:8];
                            r_reg_wdata <= alu_result;
                            if (w_fonte == 2'b11)
                                r_err <= 1'b1;
                            if (w_esc_cp) begin
                                case (w_fonte)
                                    2'b10: begin
                                        r_pc    <= w_pc_jmp;
                                        r_flush <= 1'b1;
                                    end
                                    2'b01: begin
                                        if (w_esc_cond && alu_zero) begin
                                            r_pc    <= w_pc_br;
                                            r_flush <= 1'b1;
                                        end else begin
                                            r_pc <= w_pc_inc;
                                        end
                                    end
                                    default: r_pc <= w_pc_inc;
                                endcase
                            end
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (mul_done) begin
                        r_prod  <= mul_result;
                        r_state <= S_MUL_WB;
                    end else if (r_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_pc    <= w_pc_inc;
                        r_stall <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MUL_WB: begin
                    r_reg_we    <= r_mul_we;
                    r_reg_waddr <= r_mul_dest;
                    r_reg_wdata <= r_prod;
                    r_pc        <= w_pc_inc;
                    r_stall     <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc        = r_pc;
    assign reg_we    = r_reg_we;
    assign reg_waddr = r_reg_waddr;
    assign reg_wdata = r_reg_wdata;
    assign mul_start = r_mul_start;
    assign stall     = r_stall;
    assign flush     = r_flush;
    assign err       = r_err;

endmodule

// File: tb/tb_ctrl_exec_wb.sv
// tb/tb_ctrl_exec_wb.sv - directed self-checking bench for ctrl_exec_wb
module tb_ctrl_exec_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] ctrl_in = '0;
    logic [11:0] regs_in = '0;
    logic [15:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [15:0] mul_result = '0;
    logic        mul_done = 1'b0;
    logic [11:0] pc;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic        mul_start;
    logic        stall;
    logic        flush;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    ctrl_exec_wb #(.PC_W(12), .MUL_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ctrl_in(ctrl_in), .regs_in(regs_in),
        .alu_result(alu_result), .alu_zero(alu_zero), .mul_result(mul_result), .mul_done(mul_done),
        .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .mul_start(mul_start), .stall(stall), .flush(flush), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] c, input logic [11:0] r, input logic [15:0] a, input logic z);
        ctrl_in = c; regs_in = r; alu_result = a; alu_zero = z; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (pc !== 12'h000)     begin n_errors++; $display("FAIL reset_pc got %h exp 000", pc); end
        n_checks++; if (reg_we !== 1'b0)    begin n_errors++; $display("FAIL reset_we got %b exp 0", reg_we); end
        n_checks++; if (reg_waddr !== 4'h0) begin n_errors++; $display("FAIL reset_waddr got %h exp 0", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h0) begin n_errors++; $display("FAIL reset_wdata got %h exp 0", reg_wdata); end
        n_checks++; if ({mul_start, stall, flush, err} !== 4'b0000)
            begin n_errors++; $display("FAIL reset_ctl got %b exp 0000", {mul_start, stall, flush, err}); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_alu_write();
        issue(16'h0102, 12'h3A5, 16'h1234, 1'b0);
        n_checks++; if (reg_we !== 1'b1)       begin n_errors++; $display("FAIL alu_we got %b exp 1", reg_we); end
        n_checks++; if (reg_waddr !== 4'h3)    begin n_errors++; $display("FAIL alu_waddr got %h exp 3", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h1234) begin n_errors++; $display("FAIL alu_wdata got %h exp 1234", reg_wdata); end
        n_checks++; if (pc !== 12'h001)        begin n_errors++; $display("FAIL alu_pc got %h exp 001", pc); end
        for (int i = 0; i < 4; i++) issue(16'h0002, 12'h000, 16'h0, 1'b0);
        n_checks++; if (pc !== 12'h005)        begin n_errors++; $display("FAIL nop_pc got %h exp 005", pc); end
        n_checks++; if (reg_we !== 1'b0)       begin n_errors++; $display("FAIL nop_we got %b exp 0", reg_we); end
    endtask

    task automatic test_jump();
        issue(16'h0082, 12'h0C8, 16'h0, 1'b0);
        n_checks++; if (pc !== 12'h0C8) begin n_errors++; $display("FAIL jump_pc got %h exp 0c8", pc); end
        n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL jump_flush got %b exp 1", flush); end
        n_checks++; if (reg_we !== 1'b0) begin n_errors++; $display("FAIL jump_we got %b exp 0", reg_we); end
        step();
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL jump_flush_pulse got %b exp 0", flush); end
        n_checks++; if (pc !== 12'h0C8) begin n_errors++; $display("FAIL idle_hold_pc got %h exp 0c8", pc); end
    endtask

    task automatic test_branch();
        issue(16'h0082, 12'h00A, 16'h0, 1'b0);
        issue(16'h0143, 12'hE00, 16'h5555, 1'b1);
        n_checks++; if (pc !== 12'h008)  begin n_errors++; $display("FAIL br_taken_pc got %h exp 008", pc); end
        n_checks++; if (flush !== 1'b1)  begin n_errors++; $display("FAIL br_taken_flush got %b exp 1", flush); end
        n_checks++; if (reg_we !== 1'b0) begin n_errors++; $display("FAIL br_no_write got %b exp 0", reg_we); end
        issue(16'h0082, 12'h00A, 16'h0, 1'b0);
        issue(16'h0143, 12'hE00, 16'h5555, 1'b0);
        n_checks++; if (pc !== 12'h00B) begin n_errors++; $display("FAIL br_not_taken_pc got %h exp 00b", pc); end
        n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL br_not_taken_flush got %b exp 0", flush); end
    endtask

    task automatic test_mul();
        mul_result = 16'h0F0F;
        ctrl_in = 16'h0502; regs_in = 12'h712; alu_result = 16'hDEAD; valid_in = 1'b1;
        step();
        n_checks++; if ({mul_start, stall} !== 2'b11) begin n_errors++; $display("FAIL mul_c1 start/stall got %b exp 11", {mul_start, stall}); end
        n_checks++; if (reg_we !== 1'b0 || pc !== 12'h00B) begin n_errors++; $display("FAIL mul_c1 we/pc got %b/%h exp 0/00b", reg_we, pc); end
        step();
        n_checks++; if ({mul_start, stall} !== 2'b01) begin n_errors++; $display("FAIL mul_c2 start/stall got %b exp 01", {mul_start, stall}); end
        mul_done = 1'b1;
        step();
        mul_done = 1'b0; valid_in = 1'b0;
        n_checks++; if ({mul_start, stall, reg_we} !== 3'b010) begin n_errors++; $display("FAIL mul_c4 start/stall/we got %b exp 010", {mul_start, stall, reg_we}); end
        step();
        n_checks++; if (reg_we !== 1'b1)        begin n_errors++; $display("FAIL mul_we got %b exp 1", reg_we); end
        n_checks++; if (reg_waddr !== 4'h7)     begin n_errors++; $display("FAIL mul_waddr got %h exp 7", reg_waddr); end
        n_checks++; if (reg_wdata !== 16'h0F0F) begin n_errors++; $display("FAIL mul_wdata got %h exp 0f0f", reg_wdata); end
        n_checks++; if (pc !== 12'h00C)         begin n_errors++; $display("FAIL mul_pc got %h exp 00c", pc); end
        n_checks++; if (stall !== 1'b0)         begin n_errors++; $display("FAIL mul_stall_release got %b exp 0", stall); end
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        ctrl_in = 16'h0502; regs_in = 12'h500; valid_in = 1'b1;
        step();
        for (int k = 1; k <= 16; k++) begin
            if (stall !== 1'b1 || reg_we !== 1'b0) bad++;
            if (k == 16) begin
                valid_in = 1'b0;
                n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL to_err_early got %b exp 0", err); end
            end
            step();
        end
        n_checks++; if (bad != 0)        begin n_errors++; $display("FAIL to_wait_stall bad_cycles got %0d exp 0", bad); end
        n_checks++; if (err !== 1'b1)    begin n_errors++; $display("FAIL to_err got %b exp 1", err); end
        n_checks++; if (stall !== 1'b0)  begin n_errors++; $display("FAIL to_stall got %b exp 0", stall); end
        n_checks++; if (reg_we !== 1'b0) begin n_errors++; $display("FAIL to_we got %b exp 0", reg_we); end
        n_checks++; if (pc !== 12'h00D)  begin n_errors++; $display("FAIL to_pc got %h exp 00d", pc); end
        ctrl_in = 16'h0502; regs_in = 12'h300; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({pc, stall, err, mul_start} !== 15'h0) begin n_errors++; $display("FAIL rst_mid_wait pc/stall/err/start got %h/%b/%b/%b exp 0", pc, stall, err, mul_start); end
        step();
        rst = 1'b0;
        step();
        n_checks++; if ({reg_we, stall, mul_start} !== 3'b000) begin n_errors++; $display("FAIL rst_abort got %b exp 000", {reg_we, stall, mul_start}); end
    endtask

    task automatic test_wrap_err();
        issue(16'h0082, 12'hFFF, 16'h0, 1'b0);
        issue(16'h0002, 12'h000, 16'h0, 1'b0);
        n_checks++; if (pc !== 12'h000) begin n_errors++; $display("FAIL wrap_pc got %h exp 000", pc); end
        n_checks++; if ({reg_we, flush} !== 2'b00) begin n_errors++; $display("FAIL wrap_nop we/flush got %b exp 00", {reg_we, flush}); end
        issue(16'h0143, 12'hF00, 16'h0, 1'b1);
        n_checks++; if (pc !== 12'hFFF) begin n_errors++; $display("FAIL br_neg_wrap_pc got %h exp fff", pc); end
        issue(16'h0002, 12'h000, 16'h0, 1'b0);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL err_clear got %b exp 0", err); end
        issue(16'h00C2, 12'h000, 16'h0, 1'b0);
        n_checks++; if (pc !== 12'h001 || err !== 1'b1) begin n_errors++; $display("FAIL rsv_fonte pc/err got %h/%b exp 001/1", pc, err); end
        issue(16'h0002, 12'h000, 16'h0, 1'b0);
        n_checks++; if (pc !== 12'h002 || err !== 1'b1) begin n_errors++; $display("FAIL err_sticky pc/err got %h/%b exp 002/1", pc, err); end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_jump();
        test_branch();
        test_mul();
        test_timeout();
        test_wrap_err();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
